vec_alu_seq: RTL and testbench



---
 rtl/vec_alu_pkg.sv | 30 +++
 rtl/vec_lane_alu.sv | 44 ++++
 rtl/vec_alu_seq.sv | 148 ++++++++++++++
 tb/tb_vec_alu_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// Shared types for the sequential vector ALU.
//   op_e    : 3-bit lane operation code (ADD..DUP)
//   state_e : control FSM states
//   lane_t / vec_t : element and vector types at the default geometry (N=8, V=16)
package vec_alu_pkg;

  localparam int unsigned NDef = 8;
  localparam int unsigned VDef = 16;

  typedef logic [NDef-1:0]      lane_t;
  typedef logic [VDef*NDef-1:0] vec_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_DUP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational ALU lane, N-bit unsigned.
//   a_i, b_i : lane operands
//   op_i     : operation code
//   sat_i    : saturate ADD (to all-ones) / SUB (to zero)
//   y_o      : lane result
// For DUP the caller feeds the even partner element on a_i; the lane just forwards it.
module vec_lane_alu
  import vec_alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  op_e          op_i,
  input  logic         sat_i,
  output logic [N-1:0] y_o
);

  localparam int unsigned SW = $clog2(N);

  logic [N:0]    sum;
  logic [N:0]    diff;
  logic [SW-1:0] shamt;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SW-1:0];

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_ADD: y_o = (sat_i && sum[N])  ? {N{1'b1}} : sum[N-1:0];
      OP_SUB: y_o = (sat_i && diff[N]) ? '0        : diff[N-1:0];
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_SHL: y_o = a_i << shamt;
      OP_SHR: y_o = a_i >> shamt;
      OP_DUP: y_o = a_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU: accepts one V-lane operation, processes L lanes per cycle
// over V/L cycles, then presents the full registered result.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operation handshake (A, B, Op, Sat, Mask latched on accept)
//   out_valid/out_ready : result handshake
//   Result              : registered result vector
//   Busy                : high whenever the FSM is not idle
module vec_alu_seq
  import vec_alu_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned V = 16,
  parameter int unsigned L = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [V*N-1:0] A,
  input  logic [V*N-1:0] B,
  input  logic [2:0]     Op,
  input  logic           Sat,
  input  logic [V-1:0]   Mask,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [V*N-1:0] Result,
  output logic           Busy
);

  localparam int unsigned G  = V / L;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;

  state_e           state_q, state_d;
  logic [GW-1:0]    g_q, g_d;
  logic [V*N-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  op_e              op_q, op_d;
  logic             sat_q, sat_d;
  logic [V-1:0]     mask_q, mask_d;
  logic             out_valid_q, out_valid_d;

  // Operands and results of the group selected by g_q.
  logic [L*N-1:0]   grp_a, grp_b, grp_y;
  logic [L-1:0]     grp_mask;

  always_comb begin
    grp_a    = '0;
    grp_b    = '0;
    grp_mask = '0;
    for (int gi = 0; gi < int'(G); gi++) begin
      if (g_q == GW'(gi)) begin
        grp_a    = a_q[gi*L*N +: L*N];
        grp_b    = b_q[gi*L*N +: L*N];
        grp_mask = mask_q[gi*L +: L];
      end
    end
  end

  for (genvar j = 0; j < int'(L); j++) begin : g_lane
    // Even partner within the group; L is even so pairs never cross groups.
    localparam int unsigned P = j - (j % 2);
    logic [N-1:0] lane_a, lane_y;

    assign lane_a = (op_q == OP_DUP) ? grp_a[P*N +: N] : grp_a[j*N +: N];

    vec_lane_alu #(.N(N)) u_lane (
      .a_i  (lane_a),
      .b_i  (grp_b[j*N +: N]),
      .op_i (op_q),
      .sat_i(sat_q),
      .y_o  (lane_y)
    );

    assign grp_y[j*N +: N] = grp_mask[j] ? lane_y : grp_a[j*N +: N];
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sat_d       = sat_q;
    mask_d      = mask_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          op_d    = op_e'(Op);
          sat_d   = Sat;
          mask_d  = Mask;
          g_d     = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int gi = 0; gi < int'(G); gi++) begin
          if (g_q == GW'(gi)) result_d[gi*L*N +: L*N] = grp_y;
        end
        if (g_q == GW'(G - 1)) begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      sat_q       <= 1'b0;
      mask_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      sat_q       <= sat_d;
      mask_q      <= mask_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_vec_alu_seq.sv
// Randomised and directed bench for vec_alu_seq at N=8, V=16, L=4.
module tb_vec_alu_seq;

  localparam int N = 8;
  localparam int V = 16;
  localparam int L = 4;
  localparam int W = V * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic [2:0]   op_in = 3'd0;
  logic         sat_in = 1'b0;
  logic [V-1:0] mask_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vec_alu_seq #(.N(N), .V(V), .L(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_in),
    .B        (b_in),
    .Op       (op_in),
    .Sat      (sat_in),
    .Mask     (mask_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (result),
    .Busy     (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: each lane computed with integer arithmetic from the operation rules.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input int op, input bit sat, input logic [V-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < V; i++) begin
      int ai, bi, s, sh;
      ai = int'(a[i*N +: N]);
      bi = int'(b[i*N +: N]);
      sh = bi % N;
      case (op)
        0: begin s = ai + bi; if (s > 255) s = sat ? 255 : s - 256; end
        1: begin s = ai - bi; if (s < 0) s = sat ? 0 : s + 256; end
        2: s = ai & bi;
        3: s = ai | bi;
        4: s = ai ^ bi;
        5: s = (ai << sh) % 256;
        6: s = ai >> sh;
        default: s = int'(a[(i / 2) * 2 * N +: N]);
      endcase
      if (!m[i]) s = ai;
      r[i*N +: N] = s[N-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] splat(input logic [7:0] v);
    return {V{v}};
  endfunction

  function automatic logic [W-1:0] ramp();
    logic [W-1:0] r;
    for (int i = 0; i < V; i++) r[i*N +: N] = 8'(i);
    return r;
  endfunction

  // Issue one operation, check latency and result, hold off out_ready for bp cycles,
  // then complete the output handshake. hold keeps in_valid high with fresh garbage.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int op, input bit sat, input logic [V-1:0] m,
                        input int bp, input bit hold);
    logic [W-1:0] exp;
    int lat;
    exp = model(a, b, op, sat, m);
    check({tag, ".in_ready"}, W'(in_ready), W'(1));
    a_in = a; b_in = b; op_in = 3'(op); sat_in = sat; mask_in = m; in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    if (hold) begin
      a_in = {$urandom, $urandom, $urandom, $urandom};
      b_in = {$urandom, $urandom, $urandom, $urandom};
      op_in = 3'($urandom); mask_in = 16'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    check({tag, ".busy"}, W'({busy, in_ready}), W'(2'b10));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, W'(lat), W'(V / L));
    check({tag, ".result"}, result, exp);
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check({tag, ".bp_hold"}, result, exp);
      check({tag, ".bp_flags"}, W'({out_valid, in_ready, busy}), W'(3'b101));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, ".after_hs"}, W'({out_valid, in_ready, busy}), W'(3'b010));
  endtask

  initial begin
    #12;
    check("reset.flags", W'({out_valid, in_ready, busy}), W'(3'b010));
    check("reset.result", result, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_ramp", ramp(), splat(8'h01), 0, 1'b0, 16'hFFFF, 0, 1'b0);
    run_op("add_wrap", splat(8'hF0), splat(8'h20), 0, 1'b0, 16'hFFFF, 0, 1'b0);
    check("add_wrap.value", result, splat(8'h10));
    run_op("add_sat", splat(8'hF0), splat(8'h20), 0, 1'b1, 16'hFFFF, 0, 1'b0);
    check("add_sat.value", result, splat(8'hFF));
    run_op("sub_sat", splat(8'h10), splat(8'h20), 1, 1'b1, 16'hFFFF, 0, 1'b0);
    check("sub_sat.value", result, splat(8'h00));
    run_op("sub_wrap", splat(8'h10), splat(8'h20), 1, 1'b0, 16'hFFFF, 0, 1'b0);
    check("sub_wrap.value", result, splat(8'hF0));
    run_op("shl", splat(8'h81), splat(8'h09), 5, 1'b0, 16'hFFFF, 0, 1'b0);
    check("shl.value", result, splat(8'h02));
    run_op("dup", ramp(), splat(8'h00), 7, 1'b0, 16'hFFFF, 0, 1'b0);
    run_op("xor_mask", splat(8'hAA), splat(8'hFF), 4, 1'b0, 16'h00FF, 0, 1'b0);
    check("xor_mask.value", result, {{8{8'hAA}}, {8{8'h55}}});
    run_op("mask_zero", ramp(), splat(8'h33), 0, 1'b0, 16'h0000, 0, 1'b0);
    run_op("backpressure", ramp(), splat(8'h5A), 3, 1'b0, 16'hFFFF, 10, 1'b1);

    // Asynchronous reset in the middle of BUSY (g=2).
    a_in = splat(8'h11); b_in = splat(8'h22); op_in = 3'd0; mask_in = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst.flags", W'({out_valid, in_ready, busy}), W'(3'b010));
    check("midrst.result", result, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst", splat(8'h7F), splat(8'h01), 0, 1'b1, 16'hA5A5, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_op("rand", {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 7)),
             1'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
